// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register with flush, global enable and 1-cycle latency
module pipe_skid_reg #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              send;

    // Both handshake signals derive only from registered valid bits, gated by
    // rdy/rst, so neither in_data nor out_ready reach the opposite side.
    assign in_ready  = rdy & rst & ~skid_valid;
    assign out_valid = rdy & rst & main_valid;
    assign out_data  = out_valid ? main_data : NOP_DATA;
    assign count     = {skid_valid, main_valid & ~skid_valid};

    assign accept = in_valid & in_ready;
    assign send   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                // FULL: in_ready is low, so only a send can move the skid up.
                if (send) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (main_valid) begin
                if (accept && send) begin
                    main_data <= in_data;
                end else if (accept) begin
                    skid_data  <= in_data;
                    skid_valid <= 1'b1;
                end else if (send) begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end
        end
    end

endmodule
